// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Opcode nibbles, HALT word, mnemonic and loader state types
//               shared by the program loader and the processor decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    localparam logic [3:0] c_NIB_LOAD  = 4'h1;
    localparam logic [3:0] c_NIB_ADD   = 4'h2;
    localparam logic [3:0] c_NIB_JMP   = 4'h3;
    localparam logic [3:0] c_NIB_CMP   = 4'h4;
    localparam logic [7:0] c_HALT_WORD = 8'h80;

    typedef enum logic [2:0] {
        MN_LOAD = 3'd0,
        MN_ADD  = 3'd1,
        MN_JMP  = 3'd2,
        MN_CMP  = 3'd3,
        MN_HALT = 3'd4
    } mnemonic_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Combinational mnemonic-to-instruction-word encoder; illegal
//               mnemonics produce PAD_WORD and raise the illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] PAD_WORD = 8'h00
) (
    input  logic [2:0] op,
    input  logic [3:0] imm,
    output logic [7:0] word,
    output logic       illegal
);

    always_comb begin
        word    = PAD_WORD;
        illegal = 1'b0;
        case (op)
            MN_LOAD: word = {c_NIB_LOAD, imm};
            MN_ADD:  word = {c_NIB_ADD, imm};
            MN_JMP:  word = {c_NIB_JMP, imm};
            MN_CMP:  word = {c_NIB_CMP, imm};
            MN_HALT: word = c_HALT_WORD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Streams program entries into instruction memory, padding the
//               remainder; optional XOR checksum under PROG_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] PAD_WORD = 8'h00,
    localparam int        AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [3:0]    in_imm,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
`ifdef PROG_CHECKSUM_EN
    ,
    output logic [7:0]    checksum
`endif
);

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [7:0]    w_enc;
    logic          w_illegal;
    logic          w_xfer;
    logic          w_at_end;
    logic          w_wr_en;
    logic [7:0]    w_wr_word;

    instr_encoder #(
        .PAD_WORD (PAD_WORD)
    ) u_enc (
        .op      (in_op),
        .imm     (in_imm),
        .word    (w_enc),
        .illegal (w_illegal)
    );

    assign w_xfer   = in_valid & in_ready & ~start;
    assign w_at_end = (r_ptr == c_LAST_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start overrides everything, including a coincident transfer
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == ST_LOAD);
        busy        = (r_state == ST_LOAD) || (r_state == ST_PAD);
        w_wr_en     = 1'b0;
        w_wr_word   = PAD_WORD;
        if (start) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        w_wr_en   = 1'b1;
                        w_wr_word = w_enc;
                        if (w_at_end) begin
                            w_state_nxt = ST_DONE;
                        end else if (in_last) begin
                            w_state_nxt = ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    w_wr_en = 1'b1;
                    if (w_at_end) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= w_wr_en;
            if (start) begin
                r_ptr <= '0;
                count <= '0;
                done  <= 1'b0;
                err   <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    mem_addr  <= r_ptr;
                    mem_wdata <= w_wr_word;
                    // pointer parks on the last address rather than wrapping
                    if (!w_at_end) begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                if (w_xfer) begin
                    count <= count + (AW + 1)'(1);
                    err   <= err | w_illegal;
                end
                if (r_state == ST_DONE) begin
                    done <= 1'b1;
                    if (in_valid) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (start) begin
            r_csum <= '0;
        end else if (w_wr_en) begin
            r_csum <= r_csum ^ w_wr_word;
        end
    end

    assign checksum = r_csum;
`endif

endmodule

`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: DEPTH, default 8, number of instruction-memory words to fill (power of two, 2..16).
REQ-002 Parameter: PAD_WORD, default 8'h00, word written to unused locations after the last entry.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-005 start  input  1  one-cycle pulse that begins a new program load.
REQ-006 in_valid  input  1  an entry is presented on in_op/in_imm/in_last.
REQ-007 in_ready  output  1  the loader accepts an entry this cycle.
REQ-008 in_op  input  3  mnemonic: 0 LOAD, 1 ADD, 2 JMP, 3 CMP, 4 HALT; 5-7 are illegal.
REQ-009 in_imm  input  4  immediate operand.
REQ-010 in_last  input  1  marks the final entry of the program.
REQ-011 mem_we  output  1  write strobe to the processor instruction memory.
REQ-012 mem_addr  output  clog2(DEPTH)  write address.
REQ-013 mem_wdata  output  8  encoded instruction word.
REQ-014 busy  output  1  a load is in progress (LOAD or PAD state).
REQ-015 done  output  1  all DEPTH words have been written; held until the next start.
REQ-016 err  output  1  sticky flag: an illegal op was seen, or an entry arrived after DEPTH words; cleared by start.
REQ-017 count  output  clog2(DEPTH)+1  number of program entries accepted, excluding padding.

Function
REQ-018 The FSM shall have four states: IDLE, LOAD, PAD, DONE; start moves any state to LOAD and clears the write pointer, count, err and done.
REQ-019 Encoding: LOAD={4'h1,imm}, ADD={4'h2,imm}, JMP={4'h3,imm}, CMP={4'h4,imm}, HALT=8'h80 regardless of imm.
REQ-020 in_ready shall be 1 only in LOAD; a transfer occurs when in_valid and in_ready are both 1 in the same cycle.
REQ-021 On a transfer, mem_we shall be 1 in the next cycle, with mem_addr set to the pointer value and mem_wdata set to the encoded word (one-cycle registered latency); the pointer then increments.
REQ-022 An illegal op shall set err and write PAD_WORD in that slot; count still increments.
REQ-023 A transfer with in_last=1 moves LOAD to PAD; from PAD the loader writes PAD_WORD to every remaining address, one per cycle, with in_ready=0.
REQ-024 When the write to address DEPTH-1 completes (from LOAD or PAD), the FSM shall enter DONE and assert done in the following cycle.
REQ-025 A transfer into address DEPTH-1 with in_last=0 still enters DONE; any in_valid seen in DONE sets err and is not written.
REQ-026 start asserted in the same cycle as a transfer: start wins, the entry is dropped, the pointer goes to 0.
REQ-027 start asserted in PAD: padding is aborted and the load restarts at address 0.
REQ-028 The pointer shall never wrap within a load; mem_we shall never be asserted in IDLE or DONE.

Reset
REQ-029 While rst=0: state IDLE, pointer 0, count 0, mem_we 0, mem_addr 0, mem_wdata 0, in_ready 0, busy 0, done 0, err 0.
REQ-030 A reset asserted mid-load shall abandon the load immediately; any partial memory contents are left unspecified.

Configuration
REQ-031 With PROG_CHECKSUM_EN defined, the block shall add output checksum[7:0], the XOR of every mem_wdata written in the current load (padding included), cleared by start and reset, and valid when done=1.
REQ-032 Without PROG_CHECKSUM_EN, the checksum port and its logic shall be absent.

Structure
REQ-033 A shared package shall hold the opcode nibbles (1-4), HALT_WORD 8'h80, the mnemonic enumeration and the FSM state typedef; the same package is used by the processor decoder.
REQ-034 The mnemonic-to-word encoder shall be a combinational sub-module named instr_encoder; it also outputs an illegal flag.

Verification
REQ-035 start; entries {LOAD,5},{ADD,3},{HALT,last} -> words 0x15,0x23,0x80 at addresses 0-2, 0x00 at 3-7; done high; count=3.
REQ-036 start; 8 entries of {ADD,1} with in_last=0 -> addresses 0-7 = 0x21; DONE entered with no PAD cycles; a 9th in_valid sets err with no write.
REQ-037 in_op=6 in the 2nd entry -> err=1; address 1 = 0x00; later entries are written normally.
REQ-038 rst driven low during PAD at address 4 -> all outputs go to reset values asynchronously; no further mem_we.
REQ-039 start coincident with an accepted entry -> no write; the next accepted entry lands at address 0.
REQ-040 With PROG_CHECKSUM_EN, the REQ-035 load -> checksum = 0x15^0x23^0x80 = 0xB6.
